// File: rtl/cuenta1_ctrl.sv
// Requester for the start/fin counting handshake: sweeps N_REQ values from valor_ini and accumulates total/maximo.
// Define CUENTA1_CTRL_TIMEOUT_EN to compile in the per-request fin watchdog (error flag); otherwise error is tied low.
module cuenta1_ctrl #(
    parameter int N_REQ   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] valor_ini,
    output logic [2:0] Valor,
    output logic       start,
    input  logic [3:0] Cuenta,
    input  logic       fin,
    output logic       ocupado,
    output logic       hecho,
    output logic [6:0] total,
    output logic [3:0] maximo,
    output logic       error
);

    // state    | meaning
    // S_IDLE   | waiting for go; results held
    // S_LANZA  | start pulse, Valor stable
    // S_ESPERA | waiting for fin, capture Cuenta
    // S_LIBERA | waiting for fin to drop before next value
    // S_HECHO  | end-of-run pulse, release ocupado
    typedef enum logic [2:0] {
        S_IDLE,
        S_LANZA,
        S_ESPERA,
        S_LIBERA,
        S_HECHO
    } state_t;

    localparam logic [3:0] N_LAST = 4'(N_REQ);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] valor_d;
    logic [6:0] total_d;
    logic [3:0] maximo_d;
    logic       ocupado_d;

`ifdef CUENTA1_CTRL_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valor_d   = Valor;
        total_d   = total;
        maximo_d  = maximo;
        ocupado_d = ocupado;
        start     = 1'b0;
        hecho     = 1'b0;
`ifdef CUENTA1_CTRL_TIMEOUT_EN
        wd_d      = wd_q;
        error_d   = error;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    valor_d   = valor_ini;
                    total_d   = '0;
                    maximo_d  = '0;
                    cnt_d     = '0;
                    ocupado_d = 1'b1;
`ifdef CUENTA1_CTRL_TIMEOUT_EN
                    error_d   = 1'b0;
`endif
                    state_d   = S_LANZA;
                end
            end
            S_LANZA: begin
                start   = 1'b1;
`ifdef CUENTA1_CTRL_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = S_ESPERA;
            end
            S_ESPERA: begin
                if (fin) begin
                    total_d = total + {3'b000, Cuenta};
                    if (Cuenta > maximo) begin
                        maximo_d = Cuenta;
                    end
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ((cnt_q + 4'd1) == N_LAST) ? S_HECHO : S_LIBERA;
                end
`ifdef CUENTA1_CTRL_TIMEOUT_EN
                // Counter holds TIMEOUT-1 during the TIMEOUT-th ESPERA cycle.
                else if (wd_q == WD_LAST) begin
                    error_d = 1'b1;
                    state_d = S_HECHO;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            S_LIBERA: begin
                if (!fin) begin
                    valor_d = Valor + 3'd1;
                    state_d = S_LANZA;
                end
            end
            S_HECHO: begin
                hecho     = 1'b1;
                ocupado_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            Valor   <= '0;
            total   <= '0;
            maximo  <= '0;
            ocupado <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            Valor   <= valor_d;
            total   <= total_d;
            maximo  <= maximo_d;
            ocupado <= ocupado_d;
        end
    end

`ifdef CUENTA1_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            error <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            error <= error_d;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule
